// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: clears reg_mem after reset, then round-robin serializes two requesters onto it
module reg_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_BITS-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_BITS-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  init_done
);
  typedef enum logic [2:0] {INIT, IDLE, ACCESS, RD_CAP, DONE} state_t;
  state_t               state;
  logic [ADDR_BITS:0]   cnt;
  logic                 prio;
  logic                 sel;
  logic                 we_l;
  logic                 grant_b;
  // B wins when it requests alone or when it holds priority (prio=1 means B)
  assign grant_b = b_req && (!a_req || prio);
  // clear sequence, arbitration and memory access sequencing with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      prio      <= 1'b0;
      sel       <= 1'b0;
      we_l      <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wen   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        INIT: begin
          if (cnt[ADDR_BITS]) begin
            mem_wen   <= 1'b0;
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            mem_wen  <= 1'b1;
            mem_din  <= '0;
            mem_addr <= cnt[ADDR_BITS-1:0];
            cnt      <= cnt + (ADDR_BITS+1)'(1);
          end
        end
        IDLE: begin
          if (a_req || b_req) begin
            sel      <= grant_b;
            prio     <= !grant_b;
            we_l     <= grant_b ? b_we : a_we;
            mem_wen  <= grant_b ? b_we : a_we;
            mem_addr <= grant_b ? b_addr : a_addr;
            mem_din  <= grant_b ? b_wdata : a_wdata;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wen <= 1'b0;
          if (we_l) begin
            a_ack <= !sel;
            b_ack <= sel;
            state <= DONE;
          end else begin
            state <= RD_CAP;
          end
        end
        RD_CAP: begin
          if (sel) b_rdata <= mem_dout;
          else a_rdata <= mem_dout;
          a_ack <= !sel;
          b_ack <= sel;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule
